// File: rtl/sound_length_bank.sv
// Multi-channel length-counter bank for the sound unit, clocked by the 256 Hz length tick.
// Optional sticky expiry flags are built when SOUND_LEN_STICKY_EN is defined.
module sound_length_bank #(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 8
) (
  input  logic                        length_cntrl_clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           len_load,
  input  logic [NUM_CH*LEN_W-1:0]     len_data,
  input  logic [NUM_CH-1:0]           trigger,
  input  logic [NUM_CH-1:0]           dont_loop,
  input  logic [NUM_CH-1:0]           dac_en,
  output logic [NUM_CH-1:0]           active,
  output logic [NUM_CH-1:0]           expire,
  output logic [NUM_CH*(LEN_W+1)-1:0] remaining
`ifdef SOUND_LEN_STICKY_EN
  ,
  input  logic [NUM_CH-1:0]           sticky_clr,
  output logic [NUM_CH-1:0]           sticky_expired
`endif
);

  localparam logic [LEN_W:0] FULL = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0] ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0] ZERO = '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [LEN_W:0] cnt_q, cnt_d;
      logic [LEN_W:0] load_val;
      logic [LEN_W:0] base;
      logic           active_q, active_d;
      logic           expire_q, expire_d;

      assign load_val = FULL - {1'b0, len_data[gi*LEN_W +: LEN_W]};

      // Load and trigger both suppress the tick decrement; trigger sees the freshly loaded value.
      always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        expire_d = 1'b0;
        base     = len_load[gi] ? load_val : cnt_q;
        if (!dac_en[gi]) begin
          active_d = 1'b0;
        end else if (trigger[gi]) begin
          active_d = 1'b1;
          cnt_d    = (base == ZERO) ? FULL : base;
        end else if (len_load[gi]) begin
          cnt_d = load_val;
        end else if (active_q && dont_loop[gi] && (cnt_q != ZERO)) begin
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) begin
            active_d = 1'b0;
            expire_d = 1'b1;
          end
        end
      end

      always_ff @(posedge length_cntrl_clk) begin
        if (reset) begin
          cnt_q    <= FULL;
          active_q <= 1'b0;
          expire_q <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          active_q <= active_d;
          expire_q <= expire_d;
        end
      end

      assign active[gi] = active_q;
      assign expire[gi] = expire_q;
      assign remaining[gi*(LEN_W+1) +: LEN_W+1] = cnt_q;

`ifdef SOUND_LEN_STICKY_EN
      logic sticky_q, sticky_d;

      // A new expiry outranks a clear arriving on the same edge.
      always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr[gi]) sticky_d = 1'b0;
        if (expire_d)       sticky_d = 1'b1;
      end

      always_ff @(posedge length_cntrl_clk) begin
        if (reset) sticky_q <= 1'b0;
        else       sticky_q <= sticky_d;
      end

      assign sticky_expired[gi] = sticky_q;
`endif
    end
  endgenerate

endmodule
